// File: rtl/stats_uart_reporter.sv
// -----------------------------------------------------------------------------
// stats_uart_reporter
//   Sends the end-of-run cache statistics to the host as fixed-format ASCII text
//   over an 8N1 UART TX line. A start pulse captures the instruction total and
//   the eight cache counters. Each value then goes out as one line:
//   3-char label, '=', 8 uppercase hex digits (MSB nibble first), CR, LF.
//   Label order: INS ACC EVI WRH RDH WRM RDM HIT MIS (9 lines, 126 bytes).
//
//   Optional feature macro: STATS_BANNER_EN
//     When defined, the report is prefixed with "== LRU STATS ==" CR LF
//     (17 bytes, 143 bytes total). When undefined, no banner logic exists.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset, aborts any report in flight
//   start           one-cycle report request, honoured only when idle
//   instTotal ..
//   missTotal       32-bit counters, captured on an accepted start
//   busy            high from the first start bit to the last stop bit
//   done            one-cycle pulse when the last stop bit completes
//   uart_tx         serial output, idle high
// -----------------------------------------------------------------------------
module stats_uart_reporter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instTotal,
    input  logic [31:0] accessesTotal,
    input  logic [31:0] evictionTotal,
    input  logic [31:0] writeHitTotal,
    input  logic [31:0] readHitTotal,
    input  logic [31:0] writeMissTotal,
    input  logic [31:0] readMissTotal,
    input  logic [31:0] hitTotal,
    input  logic [31:0] missTotal,
    output logic        busy,
    output logic        done,
    output logic        uart_tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    line_q, line_d;
    logic [4:0]    char_q, char_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   snap_q [0:8];
    logic [31:0]   snap_d [0:8];
    logic          in_banner;

`ifdef STATS_BANNER_EN
    localparam logic [119:0] BANNER = "== LRU STATS ==";
    logic banner_q, banner_d;
    assign in_banner = banner_q;

    function automatic logic [7:0] banner_char(input logic [4:0] c);
        if (c == 5'd15)      return 8'h0D;
        else if (c == 5'd16) return 8'h0A;
        else                 return 8'(BANNER >> (8 * (14 - int'(c))));
    endfunction
`else
    assign in_banner = 1'b0;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] label_char(input logic [3:0] line, input logic [1:0] idx);
        logic [23:0] lbl;
        case (line)
            4'd0:    lbl = "INS";
            4'd1:    lbl = "ACC";
            4'd2:    lbl = "EVI";
            4'd3:    lbl = "WRH";
            4'd4:    lbl = "RDH";
            4'd5:    lbl = "WRM";
            4'd6:    lbl = "RDM";
            4'd7:    lbl = "HIT";
            default: lbl = "MIS";
        endcase
        case (idx)
            2'd0:    return lbl[23:16];
            2'd1:    return lbl[15:8];
            default: return lbl[7:0];
        endcase
    endfunction

    // Byte currently being serialized, derived from the line/char indices.
    logic [31:0] word;
    logic [2:0]  nib_sel;
    logic [3:0]  nib;
    logic [7:0]  byte_cur;

    always_comb begin
        word     = snap_q[line_q];
        // chars 4..11 carry nibbles 7..0
        nib_sel  = 3'(4'd11 - char_q[3:0]);
        nib      = 4'(word >> {nib_sel, 2'b00});
        if (char_q < 5'd3)        byte_cur = label_char(line_q, char_q[1:0]);
        else if (char_q == 5'd3)  byte_cur = 8'h3D;
        else if (char_q <= 5'd11) byte_cur = hex_char(nib);
        else if (char_q == 5'd12) byte_cur = 8'h0D;
        else                      byte_cur = 8'h0A;
`ifdef STATS_BANNER_EN
        if (in_banner) byte_cur = banner_char(char_q);
`endif
    end

    logic bit_end;
    logic last_byte;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        line_d  = line_q;
        char_d  = char_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        snap_d  = snap_q;
`ifdef STATS_BANNER_EN
        banner_d = banner_q;
`endif
        bit_end   = (timer_q == TW'(CLKS_PER_BIT - 1));
        last_byte = !in_banner && (line_q == 4'd8) && (char_q == 5'd13);

        // Bit timer runs only while a bit is on the line; reloads every boundary.
        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP)
            timer_d = bit_end ? '0 : timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d[0] = instTotal;
                    snap_d[1] = accessesTotal;
                    snap_d[2] = evictionTotal;
                    snap_d[3] = writeHitTotal;
                    snap_d[4] = readHitTotal;
                    snap_d[5] = writeMissTotal;
                    snap_d[6] = readMissTotal;
                    snap_d[7] = hitTotal;
                    snap_d[8] = missTotal;
                    state_d   = S_START;
                    timer_d   = '0;
                    line_d    = '0;
                    char_d    = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef STATS_BANNER_EN
                    banner_d  = 1'b1;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = byte_cur[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = byte_cur[bit_q + 1'b1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_byte) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        // Next start bit follows with no idle gap.
                        state_d = S_START;
                        tx_d    = 1'b0;
`ifdef STATS_BANNER_EN
                        if (in_banner) begin
                            if (char_q == 5'd16) begin
                                banner_d = 1'b0;
                                char_d   = '0;
                            end else begin
                                char_d   = char_q + 1'b1;
                            end
                        end else
`endif
                        if (char_q == 5'd13) begin
                            char_d = '0;
                            line_d = line_q + 1'b1;
                        end else begin
                            char_d = char_q + 1'b1;
                        end
                    end
                end
            end
            // One-cycle hold so a start coinciding with done is dropped.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            line_q  <= '0;
            char_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) snap_q[i] <= '0;
`ifdef STATS_BANNER_EN
            banner_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
            char_q  <= char_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 9; i++) snap_q[i] <= snap_d[i];
`ifdef STATS_BANNER_EN
            banner_q <= banner_d;
`endif
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/stats_uart_reporter.md
Name: stats_uart_reporter

Overview:
- Transmits the end-of-run cache statistics to the host PC over the UART TX line as fixed-format ASCII text.
- On a start pulse (driven from the SD decoder's endFile), it snapshots the instruction total and the eight cache counters. It formats each as uppercase hex and serializes the result as 8N1.
- It complements the VGA stats display and is the outbound end of the host UART link.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 2.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse requesting a report
- instTotal  input  32  instruction count
- accessesTotal  input  32  cache accesses
- evictionTotal  input  32  evictions
- writeHitTotal  input  32  write hits
- readHitTotal  input  32  read hits
- writeMissTotal  input  32  write misses
- readMissTotal  input  32  read misses
- hitTotal  input  32  total hits
- missTotal  input  32  total misses
- busy  output  1  high while a report is in progress
- done  output  1  one-cycle pulse when the last stop bit completes
- uart_tx  output  1  serial out, idle high

Behaviour:
- Reset values: uart_tx=1, busy=0, done=0. All counters, snapshot registers and FSM return to IDLE.
- Reset mid-report aborts immediately. uart_tx=1 after the reset edge, and no done is issued.
- Snapshot: on the edge where start=1 and the FSM is in IDLE, all nine inputs are registered. Inputs are ignored thereafter until the next report.
- Start while busy is ignored; no queuing.
- Report format: 9 lines of 14 bytes each, 126 bytes total.
  - Each line is 3-char label, '=', 8 hex digits MSB-nibble first, CR (0x0D), LF (0x0A).
  - Label order: INS, ACC, EVI, WRH, RDH, WRM, RDM, HIT, MIS.
  - Hex digits are uppercase: nibble 0-9 -> 0x30+n, nibble A-F -> 0x37+n.
- Formatter counters:
  - line index 0..8 and char index 0..13.
  - Char 13 -> 0 advances the line.
  - Line 8 char 13 is the final byte.
- FSM states: IDLE -> START_BIT -> DATA (8 bits, LSB first) -> STOP_BIT -> (next byte: START_BIT | last byte: DONE) -> IDLE.
- Bit timing: each bit is held exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads on every bit boundary.
- uart_tx falls on the first edge after start is sampled.
- busy rises on the same edge as that first start bit.
- Bytes go back-to-back: the next start bit begins on the cycle immediately after the previous stop bit's last cycle, with no inter-byte idle.
- done pulses exactly 126×10×CLKS_PER_BIT cycles after uart_tx first falls. busy falls on that same edge. FSM is in IDLE and accepts a new start on the following cycle.
- A start coincident with the done cycle is ignored.
- Counter values of 0x00000000 and 0xFFFFFFFF print as "00000000" and "FFFFFFFF".

Optional Feature:
- Macro: STATS_BANNER_EN.
- Defined: the report is prefixed with the 17-byte banner "== LRU STATS ==" CR LF, giving 143 bytes total. done follows 143×10×CLKS_PER_BIT cycles after the first start bit.
- Undefined: no banner; 126 bytes as above. No banner logic is synthesized.

Test Plan:
- Reset then idle 100 cycles -> uart_tx=1, busy=0, done=0 throughout.
- CLKS_PER_BIT=4, instTotal=0x0000ABCD, others 0, start pulse -> UART monitor decodes:
  - first line "INS=0000ABCD\r\n"
  - then "ACC=00000000\r\n" … "MIS=00000000\r\n"
  - done exactly 5040 cycles after the first falling edge, single-cycle.
- CLKS_PER_BIT=4, all inputs 0xFFFFFFFF; change inputs to 0x12345678 one cycle after start -> all lines show "FFFFFFFF" (snapshot held).
- Second start pulse 200 cycles into a report -> ignored; exactly 126 bytes and one done pulse.
- Assert rst at byte 40 mid-data-bit -> uart_tx=1 next cycle, busy=0, no done; new start afterward yields a complete correct 126-byte report.
- STATS_BANNER_EN defined, CLKS_PER_BIT=4 -> first 17 bytes "== LRU STATS ==\r\n", then the stats lines; done 5720 cycles after the first falling edge.
